// File: rtl/cdc_pkg.sv
// Shared types and limits for the reset sequencing logic in the destination
// clock domain.
package cdc_pkg;

  typedef enum logic {
    RSEQ_HOLD = 1'b0,
    RSEQ_RUN  = 1'b1
  } rst_seq_state_e;

  localparam int RSEQ_MAX_STAGES = 16;

endpackage : cdc_pkg

// File: rtl/cdc_reset_sequencer.sv
// Releases NUM_STAGES downstream reset domains in order, HOLD_CYCLES clocks
// apart, and supports a software-requested re-reset with a one-cycle ack.
module cdc_reset_sequencer
  import cdc_pkg::*;
#(
  parameter  int NUM_STAGES  = 4,
  parameter  int HOLD_CYCLES = 8,
  localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                  dst_clk,
  input  logic                  rst_n_sync,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done,
  output logic                  sw_rst_ack
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || NUM_STAGES > RSEQ_MAX_STAGES) begin : g_bad_num_stages
    $fatal(1, "cdc_reset_sequencer: NUM_STAGES must be in 1..%0d", RSEQ_MAX_STAGES);
  end

  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $fatal(1, "cdc_reset_sequencer: HOLD_CYCLES must be >= 1");
  end

  rst_seq_state_e   state;
  logic [IDX_W-1:0] stage_idx;
  logic [CNT_W-1:0] cnt;
  logic             sw_pend;
  logic             req_q;
  logic             req_rise;

  assign req_rise = sw_rst_req & ~req_q;

  // NOTE: every register here, outputs included, is cleared by the async
  // reset and updated with non-blocking assignments only, so the block
  // models flops and the outputs drop without needing a clock edge.
  always_ff @(posedge dst_clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state       <= RSEQ_HOLD;
      stage_idx   <= '0;
      cnt         <= '0;
      sw_pend     <= 1'b0;
      req_q       <= 1'b0;
      stage_rst_n <= '0;
      seq_done    <= 1'b0;
      sw_rst_ack  <= 1'b0;
    end else begin
      req_q      <= sw_rst_req;
      sw_rst_ack <= 1'b0;

      unique case (state)
        RSEQ_HOLD: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            // Stages release strictly in order, so every bit below stage_idx
            // is already 1: shifting a 1 in sets exactly bit stage_idx.
            stage_rst_n <= (stage_rst_n << 1) | NUM_STAGES'(1);
            if (stage_idx == IDX_LAST) begin
              state      <= RSEQ_RUN;
              seq_done   <= 1'b1;
              sw_rst_ack <= sw_pend;
              sw_pend    <= 1'b0;
            end else begin
              stage_idx <= stage_idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RSEQ_RUN: begin
          if (req_rise) begin
            state       <= RSEQ_HOLD;
            stage_rst_n <= '0;
            seq_done    <= 1'b0;
            cnt         <= '0;
            stage_idx   <= '0;
            sw_pend     <= 1'b1;
          end
        end

        default: begin
          state <= RSEQ_HOLD;
        end
      endcase
    end
  end

endmodule : cdc_reset_sequencer
